// File: rtl/nasti_read_arbiter.sv
// rtl/nasti_read_arbiter.sv - N-to-1 NASTI read arbiter, one burst outstanding, R routed by grant.
// Define NASTI_RD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; default is round-robin.
module nasti_read_arbiter #(
  parameter int N_MASTER   = 2,
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [N_MASTER*ID_WIDTH-1:0]   m_ar_id_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] m_ar_addr_i,
  input  logic [N_MASTER*8-1:0]          m_ar_len_i,
  input  logic [N_MASTER*3-1:0]          m_ar_size_i,
  input  logic [N_MASTER*2-1:0]          m_ar_burst_i,
  input  logic [N_MASTER-1:0]            m_ar_lock_i,
  input  logic [N_MASTER*4-1:0]          m_ar_cache_i,
  input  logic [N_MASTER*3-1:0]          m_ar_prot_i,
  input  logic [N_MASTER*4-1:0]          m_ar_qos_i,
  input  logic [N_MASTER*4-1:0]          m_ar_region_i,
  input  logic [N_MASTER*USER_WIDTH-1:0] m_ar_user_i,
  input  logic [N_MASTER-1:0]            m_ar_valid_i,
  output logic [N_MASTER-1:0]            m_ar_ready_o,
  output logic [N_MASTER*ID_WIDTH-1:0]   m_r_id_o,
  output logic [N_MASTER*DATA_WIDTH-1:0] m_r_data_o,
  output logic [N_MASTER*2-1:0]          m_r_resp_o,
  output logic [N_MASTER-1:0]            m_r_last_o,
  output logic [N_MASTER*USER_WIDTH-1:0] m_r_user_o,
  output logic [N_MASTER-1:0]            m_r_valid_o,
  input  logic [N_MASTER-1:0]            m_r_ready_i,
  output logic [ID_WIDTH-1:0]            s_ar_id_o,
  output logic [ADDR_WIDTH-1:0]          s_ar_addr_o,
  output logic [7:0]                     s_ar_len_o,
  output logic [2:0]                     s_ar_size_o,
  output logic [1:0]                     s_ar_burst_o,
  output logic                           s_ar_lock_o,
  output logic [3:0]                     s_ar_cache_o,
  output logic [2:0]                     s_ar_prot_o,
  output logic [3:0]                     s_ar_qos_o,
  output logic [3:0]                     s_ar_region_o,
  output logic [USER_WIDTH-1:0]          s_ar_user_o,
  output logic                           s_ar_valid_o,
  input  logic                           s_ar_ready_i,
  input  logic [ID_WIDTH-1:0]            s_r_id_i,
  input  logic [DATA_WIDTH-1:0]          s_r_data_i,
  input  logic [1:0]                     s_r_resp_i,
  input  logic                           s_r_last_i,
  input  logic [USER_WIDTH-1:0]          s_r_user_i,
  input  logic                           s_r_valid_i,
  output logic                           s_r_ready_o
);

  localparam int GW    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int REQ_W = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d, grant_q, grant_d;
  logic [GW-1:0]     winner, hi_idx, lo_idx;
  logic              hi_found, any_valid;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [REQ_W-1:0]  req_vec [N_MASTER];
  logic [N_MASTER-1:0] r_sel;

  for (genvar i = 0; i < N_MASTER; i++) begin : g_port
    assign req_vec[i] = {m_ar_id_i[i*ID_WIDTH +: ID_WIDTH], m_ar_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH],
                         m_ar_len_i[i*8 +: 8], m_ar_size_i[i*3 +: 3], m_ar_burst_i[i*2 +: 2],
                         m_ar_lock_i[i], m_ar_cache_i[i*4 +: 4], m_ar_prot_i[i*3 +: 3],
                         m_ar_qos_i[i*4 +: 4], m_ar_region_i[i*4 +: 4],
                         m_ar_user_i[i*USER_WIDTH +: USER_WIDTH]};
    assign m_ar_ready_o[i] = (state_q == S_IDLE) && any_valid && (winner == GW'(i));
    assign r_sel[i]        = (state_q == S_R) && (grant_q == GW'(i));
    assign m_r_valid_o[i]  = r_sel[i] && s_r_valid_i;
    assign m_r_id_o[i*ID_WIDTH +: ID_WIDTH]         = r_sel[i] ? s_r_id_i   : '0;
    assign m_r_data_o[i*DATA_WIDTH +: DATA_WIDTH]   = r_sel[i] ? s_r_data_i : '0;
    assign m_r_resp_o[i*2 +: 2]                     = r_sel[i] ? s_r_resp_i : '0;
    assign m_r_last_o[i]                            = r_sel[i] && s_r_last_i;
    assign m_r_user_o[i*USER_WIDTH +: USER_WIDTH]   = r_sel[i] ? s_r_user_i : '0;
  end

  assign {s_ar_id_o, s_ar_addr_o, s_ar_len_o, s_ar_size_o, s_ar_burst_o, s_ar_lock_o,
          s_ar_cache_o, s_ar_prot_o, s_ar_qos_o, s_ar_region_o, s_ar_user_o} = req_q;
  assign s_ar_valid_o = (state_q == S_AR);
  assign s_r_ready_o  = |(r_sel & m_r_ready_i);

  // Lowest valid index at/above the pointer wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_found  = 1'b0;
    any_valid = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = N_MASTER - 1; i >= 0; i--) begin
      if (m_ar_valid_i[i]) begin
        lo_idx    = GW'(i);
        any_valid = 1'b1;
        if (GW'(i) >= ptr_q) begin
          hi_idx   = GW'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    req_d   = req_q;
    case (state_q)
      S_IDLE: if (any_valid) begin
        state_d = S_AR;
        grant_d = winner;
        req_d   = req_vec[winner];
`ifdef NASTI_RD_ARB_FIXED_PRIO_EN
        ptr_d   = '0;
`else
        ptr_d   = (winner == GW'(N_MASTER - 1)) ? '0 : winner + 1'b1;
`endif
      end
      S_AR:    if (s_ar_ready_i) state_d = S_R;
      S_R:     if (s_r_valid_i && s_r_ready_o && s_r_last_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_nasti_read_arbiter.sv
// tb/tb_nasti_read_arbiter.sv - directed self-checking bench for nasti_read_arbiter with N_MASTER=3.
module tb_nasti_read_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N*2-1:0]  m_ar_id;
  logic [N*32-1:0] m_ar_addr;
  logic [N*8-1:0]  m_ar_len;
  logic [N*3-1:0]  m_ar_size, m_ar_prot;
  logic [N*2-1:0]  m_ar_burst;
  logic [N-1:0]    m_ar_lock, m_ar_user, m_ar_valid, m_ar_ready;
  logic [N*4-1:0]  m_ar_cache, m_ar_qos, m_ar_region;
  logic [N*2-1:0]  m_r_id, m_r_resp;
  logic [N*64-1:0] m_r_data;
  logic [N-1:0]    m_r_last, m_r_user, m_r_valid, m_r_ready;
  logic [1:0]  s_ar_id, s_ar_burst, s_r_id, s_r_resp;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_len;
  logic [2:0]  s_ar_size, s_ar_prot;
  logic [3:0]  s_ar_cache, s_ar_qos, s_ar_region;
  logic        s_ar_lock, s_ar_user, s_ar_valid, s_ar_ready;
  logic [63:0] s_r_data;
  logic        s_r_last, s_r_user, s_r_valid, s_r_ready;

  int total = 0;
  int bad   = 0;

  nasti_read_arbiter #(.N_MASTER(N), .ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .USER_WIDTH(1)) dut (
    .clk(clk), .rstn(rstn),
    .m_ar_id_i(m_ar_id), .m_ar_addr_i(m_ar_addr), .m_ar_len_i(m_ar_len), .m_ar_size_i(m_ar_size),
    .m_ar_burst_i(m_ar_burst), .m_ar_lock_i(m_ar_lock), .m_ar_cache_i(m_ar_cache),
    .m_ar_prot_i(m_ar_prot), .m_ar_qos_i(m_ar_qos), .m_ar_region_i(m_ar_region),
    .m_ar_user_i(m_ar_user), .m_ar_valid_i(m_ar_valid), .m_ar_ready_o(m_ar_ready),
    .m_r_id_o(m_r_id), .m_r_data_o(m_r_data), .m_r_resp_o(m_r_resp), .m_r_last_o(m_r_last),
    .m_r_user_o(m_r_user), .m_r_valid_o(m_r_valid), .m_r_ready_i(m_r_ready),
    .s_ar_id_o(s_ar_id), .s_ar_addr_o(s_ar_addr), .s_ar_len_o(s_ar_len), .s_ar_size_o(s_ar_size),
    .s_ar_burst_o(s_ar_burst), .s_ar_lock_o(s_ar_lock), .s_ar_cache_o(s_ar_cache),
    .s_ar_prot_o(s_ar_prot), .s_ar_qos_o(s_ar_qos), .s_ar_region_o(s_ar_region),
    .s_ar_user_o(s_ar_user), .s_ar_valid_o(s_ar_valid), .s_ar_ready_i(s_ar_ready),
    .s_r_id_i(s_r_id), .s_r_data_i(s_r_data), .s_r_resp_i(s_r_resp), .s_r_last_i(s_r_last),
    .s_r_user_i(s_r_user), .s_r_valid_i(s_r_valid), .s_r_ready_o(s_r_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   exp_g;
    int   beat;
    int   c;
    logic p;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_ar_id[i*2 +: 2]    = 2'(i);
      m_ar_addr[i*32 +: 32] = 32'h1000 * 32'(i + 1);
    end
    m_ar_len = '0; m_ar_size = {N{3'd3}}; m_ar_burst = {N{2'd1}}; m_ar_lock = '0;
    m_ar_cache = '0; m_ar_prot = '0; m_ar_qos = '0; m_ar_region = '0; m_ar_user = '0;
    m_ar_valid = '0; m_r_ready = '0;
    s_ar_ready = 1'b0; s_r_id = 2'd0; s_r_data = '0; s_r_resp = 2'd0; s_r_last = 1'b0;
    s_r_user = 1'b0; s_r_valid = 1'b0;

    // reset state
    #3;
    chk("rst_s_ar_valid", 64'(s_ar_valid), 64'd0);
    chk("rst_s_r_ready", 64'(s_r_ready), 64'd0);
    chk("rst_m_r_valid", 64'(m_r_valid), 64'd0);
    chk("rst_m_ar_ready", 64'(m_ar_ready), 64'd0);
    chk("rst_s_ar_addr", 64'(s_ar_addr), 64'd0);
    m_ar_valid = 3'b110;
    #1;
    chk("rst_ar_ready_idle", 64'(m_ar_ready), 64'b010);
    m_ar_valid = '0;
    tick(); tick();
    rstn = 1'b1;
    m_r_ready = 3'b111;

    // all requesters continuously requesting
    m_ar_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
`ifdef NASTI_RD_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = g % 3;
`endif
      #1;
      chk("rr_ar_ready", 64'(m_ar_ready), 64'(1 << exp_g));
      tick();
      chk("rr_s_ar_valid", 64'(s_ar_valid), 64'd1);
      chk("rr_s_ar_addr", 64'(s_ar_addr), 64'h1000 * 64'(exp_g + 1));
      chk("rr_s_ar_id", 64'(s_ar_id), 64'(exp_g));
      s_ar_ready = 1'b1;
      tick();
      s_ar_ready = 1'b0;
      s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'hC0DE_0000 + 64'(g);
      #1;
      chk("rr_s_ar_valid_off", 64'(s_ar_valid), 64'd0);
      chk("rr_m_r_valid", 64'(m_r_valid), 64'(1 << exp_g));
      chk("rr_m_r_data", m_r_data[exp_g*64 +: 64], 64'hC0DE_0000 + 64'(g));
      chk("rr_ar_ready_busy", 64'(m_ar_ready), 64'd0);
      tick();
      s_r_valid = 1'b0; s_r_last = 1'b0;
    end
    m_ar_valid = '0;

    // requester 1 alone, len=3 at 0x100, with R backpressure 1,0,0,1
    m_ar_addr[32 +: 32] = 32'h100;
    m_ar_len[8 +: 8]    = 8'd3;
    m_ar_valid = 3'b010;
    #1;
    chk("t1_ar_ready", 64'(m_ar_ready), 64'b010);
    tick();
    m_ar_valid = '0;
    chk("t1_s_ar_addr", 64'(s_ar_addr), 64'h100);
    chk("t1_s_ar_len", 64'(s_ar_len), 64'd3);
    chk("t1_s_ar_valid", 64'(s_ar_valid), 64'd1);
    s_ar_ready = 1'b1;
    tick();
    s_ar_ready = 1'b0;
    beat = 0;
    c = 0;
    while (beat < 4 && c < 20) begin
      p = pat[c % 4];
      m_r_ready = {~p, p, ~p};
      s_r_valid = 1'b1; s_r_id = 2'd1;
      s_r_data = 64'hA5A5_0000 + 64'(beat);
      s_r_last = (beat == 3);
      #1;
      chk("bp_s_r_ready", 64'(s_r_ready), 64'(p));
      chk("bp_m_r_valid", 64'(m_r_valid), 64'b010);
      chk("bp_m_r_data", m_r_data[64 +: 64], 64'hA5A5_0000 + 64'(beat));
      chk("bp_other_data", m_r_data[0 +: 64] | m_r_data[128 +: 64], 64'd0);
      chk("bp_m_r_last", 64'(m_r_last), (beat == 3) ? 64'b010 : 64'd0);
      tick();
      if (p) beat++;
      c++;
    end
    s_r_valid = 1'b0; s_r_last = 1'b0; m_r_ready = 3'b111;
    chk("bp_beats", 64'(beat), 64'd4);
    #1;
    chk("t1_idle_s_r_ready", 64'(s_r_ready), 64'd0);
    chk("t1_idle_s_ar_valid", 64'(s_ar_valid), 64'd0);

    // slave holds s_ar_ready low for 5 cycles
    m_ar_addr[0 +: 32] = 32'h200;
    m_ar_len[0 +: 8]   = 8'd3;
    m_ar_valid = 3'b001;
    #1;
    chk("st_ar_ready", 64'(m_ar_ready), 64'b001);
    tick();
    m_ar_valid = 3'b111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("st_s_ar_valid", 64'(s_ar_valid), 64'd1);
      chk("st_s_ar_addr", 64'(s_ar_addr), 64'h200);
      chk("st_s_ar_len", 64'(s_ar_len), 64'd3);
      chk("st_m_ar_ready", 64'(m_ar_ready), 64'd0);
      tick();
    end
    s_ar_ready = 1'b1;
    m_ar_valid = '0;
    tick();
    s_ar_ready = 1'b0;

    // reset during beat 2 of 4
    s_r_valid = 1'b1; s_r_last = 1'b0; s_r_data = 64'hA5A5_0000;
    #1;
    chk("mr_beat1_valid", 64'(m_r_valid), 64'b001);
    tick();
    s_r_data = 64'hA5A5_0001;
    #1;
    chk("mr_beat2_valid", 64'(m_r_valid), 64'b001);
    rstn = 1'b0;
    #1;
    chk("mr_s_r_ready", 64'(s_r_ready), 64'd0);
    chk("mr_m_r_valid", 64'(m_r_valid), 64'd0);
    chk("mr_s_ar_valid", 64'(s_ar_valid), 64'd0);
    chk("mr_s_ar_addr", 64'(s_ar_addr), 64'd0);
    s_r_valid = 1'b0;
    m_ar_valid = 3'b101;
    #1;
    chk("mr_ptr_restart", 64'(m_ar_ready), 64'b001);
    m_ar_valid = 3'b100;
    #1;
    chk("mr_ar_ready2", 64'(m_ar_ready), 64'b100);
    tick();
    #3;
    rstn = 1'b1;
    tick();
    m_ar_valid = '0;
    chk("mr_s_ar_valid2", 64'(s_ar_valid), 64'd1);
    chk("mr_s_ar_addr2", 64'(s_ar_addr), 64'h3000);
    chk("mr_s_ar_id2", 64'(s_ar_id), 64'd2);
    s_ar_ready = 1'b1;
    tick();
    s_ar_ready = 1'b0;
    s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'h5A5A;
    #1;
    chk("mr_r_valid2", 64'(m_r_valid), 64'b100);
    chk("mr_r_data2", m_r_data[128 +: 64], 64'h5A5A);
    tick();
    s_r_valid = 1'b0; s_r_last = 1'b0;
    #1;
    chk("mr_end_s_r_ready", 64'(s_r_ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nasti_read_arbiter.md
# nasti_read_arbiter

Shares one NASTI read port (typically the master side of a width-narrowing reader) between N independent read requesters. Arbitrates the AR channel, forwards the winning request, and routes the R beats back to the granted requester until the last beat. At most one read burst is outstanding, which matches the single-transaction narrowing reader behind it.

## Interface
Parameters:
- N_MASTER, 2, number of requesters (2..8)
- ID_WIDTH, 2, NASTI ID width (same on both sides)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, R data width (same on both sides)
- USER_WIDTH, 1, USER field width

Ports (master-side vectors are flattened; requester i occupies slice i):
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m_ar_id/addr/len/size/burst  in  N*{ID_WIDTH,ADDR_WIDTH,8,3,2}  request fields
- m_ar_lock/cache/prot/qos/region/user  in  N*{1,4,3,4,4,USER_WIDTH}  request sideband
- m_ar_valid  in  N  request valid per requester
- m_ar_ready  out  N  one-hot-or-zero accept
- m_r_id/data/resp/last/user  out  N*{ID_WIDTH,DATA_WIDTH,2,1,USER_WIDTH}  response fields
- m_r_valid  out  N  one-hot-or-zero response valid
- m_r_ready  in  N  response ready per requester
- s_ar_id/addr/len/size/burst/lock/cache/prot/qos/region/user  out  scalar widths as above  forwarded request
- s_ar_valid  out  1 ; s_ar_ready  in  1
- s_r_id/data/resp/last/user  in  scalar widths as above
- s_r_valid  in  1 ; s_r_ready  out  1

## Operation
- FSM: S_IDLE -> S_AR on any m_ar_valid (grant taken); S_AR -> S_R on s_ar_valid && s_ar_ready; S_R -> S_IDLE on s_r_valid && s_r_ready && s_r_last.
- S_IDLE: winner computed combinationally from m_ar_valid and the priority pointer; m_ar_ready[winner]=1 only if m_ar_valid[winner]; all other bits 0. On that cycle the winner's full AR payload is registered into the request register and its index into grant (clog2(N) bits).
- Round-robin: pointer = grant+1 (mod N) after each grant; search starts at pointer, wraps past N-1 to 0.
- S_AR: s_ar_* driven from the request register unchanged (ID not modified); s_ar_valid=1 held until s_ar_ready.
- S_R: m_r_*[grant] = s_r_* (combinational pass-through); m_r_valid[grant]=s_r_valid; s_r_ready=m_r_ready[grant]; non-granted m_r_valid=0, their data fields 0.
- m_ar_ready=0 in S_AR and S_R; new requests wait, and their payload must be held stable (NASTI rule).

## Timing
- Reset (async): state=S_IDLE, pointer=0, grant=0, request register=0. s_ar_valid=0, s_r_ready=0, m_r_valid=0 at all N; m_ar_ready follows the S_IDLE rule immediately.
- AR latency: grant in cycle T; s_ar_valid high from T+1.
- R path: zero-latency combinational; no buffering, no beat counting (s_r_last is authoritative).
- Turnaround: last beat accepted in T; state=S_IDLE in T+1; next grant possible in T+1. Minimum 1 bubble cycle between bursts.
- Simultaneous last beat and new m_ar_valid: the new request is not accepted until T+1.
- Reset mid-burst: the burst is abandoned, and the slave must be reset in the same domain.

## Configuration
- NASTI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined (default): round-robin as above.

## Test plan
- Single requester 1, len=3, addr=0x100: m_ar_ready[1] in the grant cycle; s_ar_addr=0x100, len=3 next cycle; 4 beats appear only on m_r_*[1]; FSM back to S_IDLE after the last beat.
- All 3 of N=3 requesting continuously (round-robin): grant order 0,1,2,0; pointer wraps; each burst completes before the next s_ar_valid.
- Same stimulus with NASTI_RD_ARB_FIXED_PRIO_EN defined: requester 0 is granted every time while it keeps requesting, and requesters 1 and 2 starve.
- Backpressure: m_r_ready[grant] toggles 1,0,0,1: s_r_ready mirrors it each cycle; no beat is lost or duplicated; data 0xA5A5_0000+i arrives in order.
- s_ar_ready held low 5 cycles: s_ar_valid stays high and payload is stable; m_ar_ready stays 0 for all requesters throughout.
- rstn asserted during beat 2 of 4: outputs reach reset values asynchronously; after release a new request from requester 2 is granted cleanly with the pointer restarting at 0.
